// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment order, blank pattern and hex glyph table.
// Patterns are {g,f,e,d,c,b,a} with 1 = lit, independent of board polarity.
package seg7_pkg;

    typedef enum logic [2:0] {
        SEG_A = 3'd0,
        SEG_B = 3'd1,
        SEG_C = 3'd2,
        SEG_D = 3'd3,
        SEG_E = 3'd4,
        SEG_F = 3'd5,
        SEG_G = 3'd6
    } seg_idx_e;

    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

    // Entry n is the glyph for hex digit n (entry 0 sits in the low bits).
    localparam logic [15:0][SEG_W-1:0] HEX2SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational glyph source: hex decode of a nibble, or a raw pattern passthrough.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0]       nibble,
    input  logic [SEG_W-1:0] raw,
    input  logic             raw_mode,
    output logic [SEG_W-1:0] lit
);

    assign lit = raw_mode ? raw : HEX2SEG[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode display scanner with frame-synchronous shadow loading,
// leading-zero blanking, PWM brightness and a per-slot anti-ghosting guard.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int DIV        = 100000,
    parameter int PWM_BITS   = 4,
    parameter int GUARD      = 2,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [7*NUM_DIGITS-1:0] raw_seg,
    input  logic                    raw_mode,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    input  logic [PWM_BITS-1:0]     brightness,
    input  logic                    update,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [SEG_W-1:0]        cathode,
    output logic                    dp,
    output logic                    frame_sync
);

    localparam int SLOT_W = $clog2(DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int ON_W   = SLOT_W + 1;
    localparam int STEP   = DIV >> PWM_BITS;

    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [SEG_W-1:0]      CA_OFF = {SEG_W{ACTIVE_LOW}};

    logic [SLOT_W-1:0] slot_cnt;
    logic [IDX_W-1:0]  digit_idx;
    logic              pending;
    logic              boundary;
    logic              load;

    logic [4*NUM_DIGITS-1:0] sh_value;
    logic [7*NUM_DIGITS-1:0] sh_raw;
    logic                    sh_raw_mode;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_en;
    logic                    sh_lz;
    logic [PWM_BITS-1:0]     sh_bright;

    logic [4*NUM_DIGITS-1:0] eff_value;
    logic [7*NUM_DIGITS-1:0] eff_raw;
    logic                    eff_raw_mode;
    logic [NUM_DIGITS-1:0]   eff_dp;
    logic [NUM_DIGITS-1:0]   eff_en;
    logic                    eff_lz;
    logic [PWM_BITS-1:0]     eff_bright;

    logic [3:0]            cur_nib;
    logic [SEG_W-1:0]      cur_raw;
    logic                  cur_dp;
    logic                  cur_en;
    logic                  cur_blank;
    logic                  zero_run;
    logic [NUM_DIGITS-1:0] anode_sel;
    logic [SEG_W-1:0]      cur_lit;
    logic [ON_W-1:0]       on_cycles;
    logic                  slot_on;
    logic                  digit_on;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else if (slot_cnt == SLOT_W'(DIV - 1)) begin
            slot_cnt  <= '0;
            digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
        end else begin
            slot_cnt  <= slot_cnt + SLOT_W'(1);
        end
    end

    assign boundary = (digit_idx == '0) && (slot_cnt == '0);
    assign load     = boundary && (pending || update);

    // Every boundary either consumes the request or had none, so pending always clears there.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            pending <= 1'b1;
        end else if (boundary) begin
            pending <= 1'b0;
        end else if (update) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            sh_value    <= '0;
            sh_raw      <= '0;
            sh_raw_mode <= 1'b0;
            sh_dp       <= '0;
            sh_en       <= '0;
            sh_lz       <= 1'b0;
            sh_bright   <= '0;
        end else if (load) begin
            sh_value    <= value;
            sh_raw      <= raw_seg;
            sh_raw_mode <= raw_mode;
            sh_dp       <= dp_in;
            sh_en       <= digit_en;
            sh_lz       <= lz_blank;
            sh_bright   <= brightness;
        end
    end

    // The boundary cycle already renders from the contents being loaded, so the
    // first output cycle of a frame (frame_sync) shows the new frame.
    assign eff_value    = load ? value      : sh_value;
    assign eff_raw      = load ? raw_seg    : sh_raw;
    assign eff_raw_mode = load ? raw_mode   : sh_raw_mode;
    assign eff_dp       = load ? dp_in      : sh_dp;
    assign eff_en       = load ? digit_en   : sh_en;
    assign eff_lz       = load ? lz_blank   : sh_lz;
    assign eff_bright   = load ? brightness : sh_bright;

    // Walk from the most significant digit down so zero_run marks "all zero from here up".
    always_comb begin
        cur_nib   = '0;
        cur_raw   = '0;
        cur_dp    = 1'b0;
        cur_en    = 1'b0;
        cur_blank = 1'b0;
        zero_run  = 1'b1;
        anode_sel = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (eff_value[4*i +: 4] == 4'h0);
            if (digit_idx == IDX_W'(i)) begin
                anode_sel[i] = 1'b1;
                cur_nib      = eff_value[4*i +: 4];
                cur_raw      = eff_raw[7*i +: 7];
                cur_dp       = eff_dp[i];
                cur_en       = eff_en[i];
                cur_blank    = eff_lz && !eff_raw_mode && zero_run && (i != 0);
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .nibble   (cur_nib),
        .raw      (cur_raw),
        .raw_mode (eff_raw_mode),
        .lit      (cur_lit)
    );

    assign on_cycles = ON_W'((eff_bright + 32'd1) * STEP);
    assign slot_on   = ({1'b0, slot_cnt} >= ON_W'(GUARD)) && ({1'b0, slot_cnt} < on_cycles);
    assign digit_on  = slot_on && cur_en && !cur_blank;

    // XOR with the idle pattern applies board polarity in the output flops.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            anode      <= AN_OFF;
            cathode    <= CA_OFF;
            dp         <= ACTIVE_LOW;
            frame_sync <= 1'b0;
        end else begin
            anode      <= (digit_on ? anode_sel : '0) ^ AN_OFF;
            cathode    <= (digit_on ? cur_lit : SEG_OFF) ^ CA_OFF;
            dp         <= (digit_on && cur_dp) ^ ACTIVE_LOW;
            frame_sync <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with 8 digits, 16-cycle slots, 2-bit PWM, guard of 1.
// Cycle c is the c-th counter state after reset release; its outputs are sampled 1 after edge c+1.
module tb_seg7_scan_ctrl;

    logic        sys_clk;
    logic        sys_rst;
    logic [31:0] value;
    logic [55:0] raw_seg;
    logic        raw_mode;
    logic [7:0]  dp_in;
    logic [7:0]  digit_en;
    logic        lz_blank;
    logic [1:0]  brightness;
    logic        update;
    logic [7:0]  anode;
    logic [6:0]  cathode;
    logic        dp;
    logic        frame_sync;

    int n_tests = 0;
    int n_fail  = 0;
    int c;

    seg7_scan_ctrl #(
        .NUM_DIGITS (8),
        .DIV        (16),
        .PWM_BITS   (2),
        .GUARD      (1),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .value      (value),
        .raw_seg    (raw_seg),
        .raw_mode   (raw_mode),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .lz_blank   (lz_blank),
        .brightness (brightness),
        .update     (update),
        .anode      (anode),
        .cathode    (cathode),
        .dp         (dp),
        .frame_sync (frame_sync)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic do_reset();
        sys_rst = 1'b0;
        update  = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        c = 0;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        value = 32'h0123ABCD; raw_seg = '0; raw_mode = 1'b0; dp_in = 8'hFF;
        digit_en = 8'hFF; lz_blank = 1'b0; brightness = 2'd3;
        do_reset();
        repeat (20) tick();
        #2 sys_rst = 1'b0;
        #1;
        n_tests++; if (anode !== 8'hFF) begin n_fail++; $display("FAIL reset_anode got=%h exp=ff", anode); end
        n_tests++; if (cathode !== 7'h7F) begin n_fail++; $display("FAIL reset_cathode got=%h exp=7f", cathode); end
        n_tests++; if (dp !== 1'b1) begin n_fail++; $display("FAIL reset_dp got=%b exp=1", dp); end
        n_tests++; if (frame_sync !== 1'b0) begin n_fail++; $display("FAIL reset_frame_sync got=%b exp=0", frame_sync); end
        @(negedge sys_clk);
        sys_rst = 1'b1;
        c = 0;
        for (int k = 0; k <= 256; k++) begin
            tick();
            n_tests++;
            if (frame_sync !== ((c % 128) == 0)) begin
                n_fail++; $display("FAIL frame_period c=%0d frame_sync=%b exp=%b", c, frame_sync, (c % 128) == 0);
            end
            c++;
        end
    endtask

    task automatic test_hex_scan();
        logic [6:0] segs [8];
        logic [7:0] exp_an;
        logic [6:0] exp_ca;
        int slot, d;
        segs = '{7'h5E, 7'h39, 7'h7C, 7'h77, 7'h4F, 7'h5B, 7'h06, 7'h3F};
        value = 32'h0123ABCD; raw_mode = 1'b0; dp_in = 8'h00;
        digit_en = 8'hFF; lz_blank = 1'b0; brightness = 2'd3;
        do_reset();
        for (int k = 0; k < 128; k++) begin
            tick();
            slot = c % 16; d = c / 16;
            exp_an = (slot >= 1) ? (8'hFF ^ (8'h01 << d)) : 8'hFF;
            exp_ca = (slot >= 1) ? ~segs[d] : 7'h7F;
            n_tests++; if (anode !== exp_an) begin n_fail++; $display("FAIL hex_anode c=%0d got=%h exp=%h", c, anode, exp_an); end
            n_tests++; if (cathode !== exp_ca) begin n_fail++; $display("FAIL hex_cathode c=%0d got=%h exp=%h", c, cathode, exp_ca); end
            n_tests++; if (dp !== 1'b1) begin n_fail++; $display("FAIL hex_dp c=%0d got=%b exp=1", c, dp); end
            c++;
        end
    endtask

    task automatic test_lz_blank();
        logic [6:0] exp_ca;
        logic [7:0] exp_an;
        logic on;
        int slot, d;
        raw_mode = 1'b0; dp_in = 8'hFF; digit_en = 8'hFF; lz_blank = 1'b1; brightness = 2'd3;
        value = 32'h000000A5;
        do_reset();
        for (int k = 0; k < 128; k++) begin
            tick();
            slot = c % 16; d = c / 16;
            on = (slot >= 1) && (d < 2);
            exp_an = on ? (8'hFF ^ (8'h01 << d)) : 8'hFF;
            exp_ca = on ? ((d == 0) ? ~7'h6D : ~7'h77) : 7'h7F;
            n_tests++; if (anode !== exp_an) begin n_fail++; $display("FAIL lz_anode c=%0d got=%h exp=%h", c, anode, exp_an); end
            n_tests++; if (cathode !== exp_ca) begin n_fail++; $display("FAIL lz_cathode c=%0d got=%h exp=%h", c, cathode, exp_ca); end
            n_tests++; if (dp !== !on) begin n_fail++; $display("FAIL lz_dp c=%0d got=%b exp=%b", c, dp, !on); end
            c++;
        end
        value = 32'h00000000;
        do_reset();
        for (int k = 0; k < 128; k++) begin
            tick();
            slot = c % 16; d = c / 16;
            on = (slot >= 1) && (d == 0);
            exp_an = on ? 8'hFE : 8'hFF;
            exp_ca = on ? ~7'h3F : 7'h7F;
            n_tests++; if (anode !== exp_an) begin n_fail++; $display("FAIL lz0_anode c=%0d got=%h exp=%h", c, anode, exp_an); end
            n_tests++; if (cathode !== exp_ca) begin n_fail++; $display("FAIL lz0_cathode c=%0d got=%h exp=%h", c, cathode, exp_ca); end
            c++;
        end
    endtask

    task automatic test_brightness();
        int codes [2];
        int last_on [2];
        logic [7:0] exp_an;
        int slot, d;
        codes   = '{0, 2};
        last_on = '{3, 11};
        value = 32'h0123ABCD; raw_mode = 1'b0; dp_in = 8'h00; digit_en = 8'hFF; lz_blank = 1'b0;
        for (int t = 0; t < 2; t++) begin
            brightness = 2'(codes[t]);
            do_reset();
            for (int k = 0; k < 128; k++) begin
                tick();
                slot = c % 16; d = c / 16;
                exp_an = (slot >= 1 && slot <= last_on[t]) ? (8'hFF ^ (8'h01 << d)) : 8'hFF;
                n_tests++;
                if (anode !== exp_an) begin
                    n_fail++; $display("FAIL bright%0d_anode c=%0d got=%h exp=%h", codes[t], c, anode, exp_an);
                end
                c++;
            end
        end
    endtask

    task automatic test_tear_free();
        logic [6:0] exp_ca;
        int slot;
        value = 32'h11111111; raw_mode = 1'b0; dp_in = 8'h00; digit_en = 8'hFF;
        lz_blank = 1'b0; brightness = 2'd3;
        do_reset();
        for (int k = 0; k < 512; k++) begin
            tick();
            slot = c % 16;
            exp_ca = (slot >= 1) ? ((c < 128) ? ~7'h06 : ~7'h5B) : 7'h7F;
            n_tests++; if (cathode !== exp_ca) begin n_fail++; $display("FAIL tear_cathode c=%0d got=%h exp=%h", c, cathode, exp_ca); end
            n_tests++; if (frame_sync !== ((c % 128) == 0)) begin n_fail++; $display("FAIL tear_frame_sync c=%0d got=%b exp=%b", c, frame_sync, (c % 128) == 0); end
            if (c == 40) begin value = 32'h22222222; update = 1'b1; end
            if (c == 41) update = 1'b0;
            if (c == 200) value = 32'h33333333;
            c++;
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_ca;
        int slot;
        value = 32'h11111111; raw_mode = 1'b0; dp_in = 8'h00; digit_en = 8'hFF;
        lz_blank = 1'b0; brightness = 2'd3;
        do_reset();
        for (int k = 0; k < 384; k++) begin
            tick();
            slot = c % 16;
            exp_ca = (slot >= 1) ? ((c < 128) ? ~7'h06 : ~7'h66) : 7'h7F;
            n_tests++; if (cathode !== exp_ca) begin n_fail++; $display("FAIL boundary_update_cathode c=%0d got=%h exp=%h", c, cathode, exp_ca); end
            if (c == 127) begin value = 32'h44444444; update = 1'b1; end
            if (c == 128) update = 1'b0;
            if (c == 130) value = 32'h55555555;
            c++;
        end
    endtask

    task automatic test_raw_enable();
        logic [7:0] exp_an;
        logic [6:0] exp_ca;
        logic on;
        int slot, d;
        raw_seg = '1; raw_seg[27:21] = 7'h49;
        raw_mode = 1'b1; value = 32'h00000000; lz_blank = 1'b1;
        dp_in = 8'h08; digit_en = 8'h08; brightness = 2'd3;
        do_reset();
        for (int k = 0; k < 128; k++) begin
            tick();
            slot = c % 16; d = c / 16;
            on = (slot >= 1) && (d == 3);
            exp_an = on ? 8'hF7 : 8'hFF;
            exp_ca = on ? ~7'h49 : 7'h7F;
            n_tests++; if (anode !== exp_an) begin n_fail++; $display("FAIL raw_anode c=%0d got=%h exp=%h", c, anode, exp_an); end
            n_tests++; if (cathode !== exp_ca) begin n_fail++; $display("FAIL raw_cathode c=%0d got=%h exp=%h", c, cathode, exp_ca); end
            n_tests++; if (dp !== !on) begin n_fail++; $display("FAIL raw_dp c=%0d got=%b exp=%b", c, dp, !on); end
            c++;
        end
    endtask

    initial begin
        sys_rst = 1'b0; update = 1'b0; value = '0; raw_seg = '0; raw_mode = 1'b0;
        dp_in = '0; digit_en = '0; lz_blank = 1'b0; brightness = '0;
        test_reset();
        test_hex_scan();
        test_lz_blank();
        test_brightness();
        test_tear_free();
        test_back_to_back();
        test_raw_enable();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
